// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared pipeline constants for the fetch stage and its IF/ID
//               register: datapath width, default reset PC, bubble and halt
//               instruction words, and the fetch FSM state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. Priority: rst > flush > hold > load.
//               A flush inserts a bubble (valid=0, instr=NOP_INSTR, PCs 0).
// Ports       : clk, rst (async, active-high), hold, flush,
//               d_valid/d_pc/d_pc_plus4/d_instr  - next contents,
//               q_valid/q_pc/q_pc_plus4/q_instr  - registered contents.
// Revision    : 1.0  initial release
// ============================================================================
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_pc_plus4,
  input  logic [XLEN-1:0] d_instr,
  output logic            q_valid,
  output logic [XLEN-1:0] q_pc,
  output logic [XLEN-1:0] q_pc_plus4,
  output logic [XLEN-1:0] q_instr
);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] instr_q,    instr_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      pc_plus4_d = '0;
      instr_d    = NOP_INSTR;
    end else if (!hold) begin
      valid_d    = d_valid;
      pc_d       = d_pc;
      pc_plus4_d = d_pc_plus4;
      instr_d    = d_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign q_valid    = valid_q;
  assign q_pc       = pc_q;
  assign q_pc_plus4 = pc_plus4_q;
  assign q_instr    = instr_q;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Single-issue instruction fetch. PC drives instruction memory
//               combinationally; the returned word is captured into IF/ID one
//               cycle later. Supports stall, redirect (flush) and a halt
//               instruction that parks the PC until the next redirect.
// Ports       : clk, rst (async, active-high)
//               stall, redirect_valid, redirect_pc      - control inputs
//               imem_addr (out), imem_instr (in)        - instruction memory
//               ifid_valid/pc/pc_plus4/instr            - IF/ID contents
//               halted, fetch_count                      - status
// Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
  parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            halted,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_hold;
  logic            ifid_flush;

  // Redirect targets are word aligned; the two low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      state_d    = RUN;
      ifid_flush = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else if (state_q == HALTED) begin
      // Parked: PC holds, IF/ID drains to bubbles.
      ifid_flush = 1'b1;
    end else begin
      if (fetch_count_q != '1) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
      // The halt word itself is delivered; only the PC stops advancing.
      if (imem_instr == HALT_INSTR) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .hold       (ifid_hold),
    .flush      (ifid_flush),
    .d_valid    (1'b1),
    .d_pc       (pc_q),
    .d_pc_plus4 (pc_plus4),
    .d_instr    (imem_instr),
    .q_valid    (ifid_valid),
    .q_pc       (ifid_pc),
    .q_pc_plus4 (ifid_pc_plus4),
    .q_instr    (ifid_instr)
  );

  assign imem_addr   = pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

endmodule : fetch_stage
`default_nettype wire
